// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Inputs are snapshotted once per frame; each digit slot opens with an all-off dead time.
module sevenseg_scan_driver #(
   parameter int DIGIT_PERIOD = 100000,
   parameter int DEAD_CYCLES  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits_bcd,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  digit_en,
   input  logic        lz_blank,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_start
);

   localparam int               CNT_W    = $clog2(DIGIT_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
      case (code)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic [15:0]      shadow_bcd;
   logic [3:0]       shadow_dp;
   logic [3:0]       shadow_en;
   logic             shadow_lz;
   logic             load_pending;

   logic             load_p0;
   logic             dead_p0;
   logic             dark_p0;
   logic [3:0]       code_p0;
   logic             zero3_p0;
   logic             zero2_p0;
   logic             zero1_p0;
   logic [3:0]       lz_sup_p0;

   // Stage p0: decode the current slot from the snapshot.
   always_comb begin
      load_p0   = load_pending || (cnt == CNT_LAST && idx == 2'd3);
      dead_p0   = cnt < CNT_DEAD;
      code_p0   = shadow_bcd[{idx, 2'b00} +: 4];
      zero3_p0  = shadow_bcd[15:12] == 4'd0;
      zero2_p0  = zero3_p0 && (shadow_bcd[11:8] == 4'd0);
      zero1_p0  = zero2_p0 && (shadow_bcd[7:4] == 4'd0);
      // Digit0 always shows, so a value of zero still reads "0".
      lz_sup_p0 = shadow_lz ? {zero3_p0, zero2_p0, zero1_p0, 1'b0} : 4'b0000;
      dark_p0   = !shadow_en[idx] || (code_p0 > 4'd9) || lz_sup_p0[idx];
   end

   // Stage p1: registered scan state, snapshot and display outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         idx          <= 2'd0;
         shadow_bcd   <= '0;
         shadow_dp    <= '0;
         shadow_en    <= '0;
         shadow_lz    <= 1'b0;
         load_pending <= 1'b1;
         seg          <= 7'b1111111;
         dp           <= 1'b1;
         an           <= 4'b1111;
         frame_start  <= 1'b0;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         load_pending <= 1'b0;
         frame_start  <= load_p0;
         if (load_p0) begin
            shadow_bcd <= digits_bcd;
            shadow_dp  <= dp_in;
            shadow_en  <= digit_en;
            shadow_lz  <= lz_blank;
         end

         if (dead_p0 || dark_p0) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
         end else begin
            an  <= ~(4'b0001 << idx);
            seg <= bcd_to_seg(code_p0);
            dp  <= ~shadow_dp[idx];
         end
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver with DIGIT_PERIOD=8, DEAD_CYCLES=2.
// A frame-timing model pushes expected outputs each clock; scenarios pop and compare.
module tb_sevenseg_scan_driver;

   localparam int          DIG_P   = 8;
   localparam int          DEAD_C  = 2;
   localparam int          FRAME   = 4 * DIG_P;
   localparam logic [12:0] RST_VAL = 13'b1111_1111111_1_0;
   localparam logic [6:0]  S_0 = 7'b0000001;
   localparam logic [6:0]  S_1 = 7'b1001111;
   localparam logic [6:0]  S_2 = 7'b0010010;
   localparam logic [6:0]  S_3 = 7'b0000110;
   localparam logic [6:0]  S_4 = 7'b1001100;
   localparam logic [6:0]  S_5 = 7'b0100100;
   localparam logic [6:0]  S_9 = 7'b0000100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] digits_bcd = 16'h0000;
   logic [3:0]  dp_in = 4'h0;
   logic [3:0]  digit_en = 4'h0;
   logic        lz_blank = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_start;

   int checks = 0;
   int errors = 0;

   logic [12:0] sb_q[$];
   logic [12:0] cap_obs [32];
   logic [12:0] cap_exp [32];

   int          m_cyc = 0;
   logic [15:0] m_bcd = '0;
   logic [3:0]  m_dp = '0;
   logic [3:0]  m_en = '0;
   logic        m_lz = 1'b0;
   logic        m_ld;
   logic [12:0] m_exp;

   always #5 clk = ~clk;

   sevenseg_scan_driver #(.DIGIT_PERIOD(DIG_P), .DEAD_CYCLES(DEAD_C)) dut (
      .clk         (clk),
      .rst         (rst),
      .digits_bcd  (digits_bcd),
      .dp_in       (dp_in),
      .digit_en    (digit_en),
      .lz_blank    (lz_blank),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .frame_start (frame_start)
   );

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return S_0;
         4'd1: return S_1;
         4'd2: return S_2;
         4'd3: return S_3;
         4'd4: return S_4;
         4'd5: return S_5;
         4'd6: return 7'b0100000;
         4'd7: return 7'b0001111;
         4'd8: return 7'b0000000;
         4'd9: return S_9;
         default: return 7'b1111111;
      endcase
   endfunction

   // {an, seg, dp} for slot s at position c within the slot.
   function automatic logic [11:0] disp(input logic [15:0] b, input logic [3:0] p,
                                        input logic [3:0] e, input logic z, input int s, input int c);
      logic [11:0] r;
      logic [3:0]  code;
      logic [3:0]  a;
      logic        dark;
      logic        all_zero;
      r = {4'b1111, 7'b1111111, 1'b1};
      if (c < DEAD_C) return r;
      code = b[s*4 +: 4];
      dark = (e[s] == 1'b0) || (code > 4'd9);
      if (z && s > 0) begin
         all_zero = 1'b1;
         for (int j = s; j < 4; j++)
            if (b[j*4 +: 4] != 4'd0) all_zero = 1'b0;
         dark = dark || all_zero;
      end
      if (!dark) begin
         a    = 4'b1111;
         a[s] = 1'b0;
         r    = {a, seg_of(code), ~p[s]};
      end
      return r;
   endfunction

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_cyc = 0;
         m_bcd = '0;
         m_dp  = '0;
         m_en  = '0;
         m_lz  = 1'b0;
         m_exp = RST_VAL;
      end else begin
         m_ld  = (m_cyc == 0) || (m_cyc % FRAME == FRAME - 1);
         m_exp = {disp(m_bcd, m_dp, m_en, m_lz, (m_cyc / DIG_P) % 4, m_cyc % DIG_P), m_ld};
         if (m_ld) begin
            m_bcd = digits_bcd;
            m_dp  = dp_in;
            m_en  = digit_en;
            m_lz  = lz_blank;
         end
         m_cyc++;
      end
      sb_q.push_back(m_exp);
   end

   task automatic step(output logic [12:0] o, output logic [12:0] e);
      @(negedge clk);
      o = {an, seg, dp, frame_start};
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = 'x;
   endtask

   task automatic capture(input int n, input int base);
      for (int i = 0; i < n; i++) step(cap_obs[base+i], cap_exp[base+i]);
   endtask

   task automatic wait_frame(output bit ok);
      logic [12:0] o, e;
      ok = 1'b0;
      for (int i = 0; i < 80 && !ok; i++) begin
         step(o, e);
         ok = (o[0] === 1'b1);
      end
   endtask

   task automatic test_reset();
      logic [12:0] o, e;
      rst        = 1'b1;
      digits_bcd = 16'($urandom);
      dp_in      = 4'($urandom);
      digit_en   = 4'($urandom);
      lz_blank   = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
         step(o, e);
         checks++;
         if (o !== RST_VAL) begin errors++; $display("FAIL reset_hold got=%b want=%b", o, RST_VAL); end
         checks++;
         if (o !== e) begin errors++; $display("FAIL reset_sb got=%b want=%b", o, e); end
      end
      digits_bcd = 16'h1234;
      digit_en   = 4'b1111;
      dp_in      = 4'b0000;
      lz_blank   = 1'b0;
      rst        = 1'b0;
      step(o, e);
      checks++;
      if (o[0] !== 1'b1) begin errors++; $display("FAIL frame_start_c1 got=%b want=1", o[0]); end
      checks++;
      if (o !== e) begin errors++; $display("FAIL release_sb_c1 got=%b want=%b", o, e); end
      step(o, e);
      checks++;
      if (o[0] !== 1'b0) begin errors++; $display("FAIL frame_start_c2 got=%b want=0", o[0]); end
      checks++;
      if (o !== e) begin errors++; $display("FAIL release_sb_c2 got=%b want=%b", o, e); end
   endtask

   task automatic test_basic_scan();
      int lit [4];
      int fs_cnt, fs_idx;
      logic [3:0] a;
      logic [6:0] s;
      for (int w = 0; w < 2; w++) begin
         capture(32, 0);
         lit = '{0, 0, 0, 0};
         fs_cnt = 0;
         fs_idx = -1;
         for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap_obs[i] !== cap_exp[i]) begin
               errors++; $display("FAIL basic_sb w=%0d i=%0d got=%b want=%b", w, i, cap_obs[i], cap_exp[i]);
            end
            a = cap_obs[i][12:9];
            s = cap_obs[i][8:2];
            if (a == 4'b1110 && s == S_4) lit[0]++;
            if (a == 4'b1101 && s == S_3) lit[1]++;
            if (a == 4'b1011 && s == S_2) lit[2]++;
            if (a == 4'b0111 && s == S_1) lit[3]++;
            if (cap_obs[i][0] === 1'b1) begin fs_cnt++; fs_idx = i; end
         end
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (lit[k] != DIG_P - DEAD_C) begin
               errors++; $display("FAIL basic_lit digit=%0d got=%0d want=%0d", k, lit[k], DIG_P - DEAD_C);
            end
         end
         checks++;
         if (fs_cnt != 1 || fs_idx != 29) begin
            errors++; $display("FAIL basic_frame_start cnt=%0d idx=%0d want cnt=1 idx=29", fs_cnt, fs_idx);
         end
      end
   endtask

   task automatic test_leading_zero();
      logic [15:0] pat [3];
      int hi, d0, d1, d2, d3, other;
      bit ok;
      logic [3:0] a;
      logic [6:0] s;
      pat = '{16'h0042, 16'h0000, 16'h0102};
      for (int t = 0; t < 3; t++) begin
         digits_bcd = pat[t];
         lz_blank   = 1'b1;
         digit_en   = 4'b1111;
         dp_in      = 4'b0000;
         wait_frame(ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL lz_timeout case=%0d got=0 want=1", t); end
         capture(32, 0);
         hi = 0; d0 = 0; d1 = 0; d2 = 0; d3 = 0; other = 0;
         for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap_obs[i] !== cap_exp[i]) begin
               errors++; $display("FAIL lz_sb case=%0d i=%0d got=%b want=%b", t, i, cap_obs[i], cap_exp[i]);
            end
            a = cap_obs[i][12:9];
            s = cap_obs[i][8:2];
            if (a == 4'b0111 || a == 4'b1011) hi++;
            if (a == 4'b1110 && s == (t == 0 ? S_2 : (t == 1 ? S_0 : S_2))) d0++;
            if (a == 4'b1101 && s == (t == 0 ? S_4 : S_0)) d1++;
            if (a == 4'b1011 && s == S_1) d2++;
            if (a == 4'b0111) d3++;
            if (a != 4'b1111 && !(a == 4'b1110 && s == S_0)) other++;
         end
         checks++;
         if (d0 != 6) begin errors++; $display("FAIL lz_digit0 case=%0d got=%0d want=6", t, d0); end
         checks++;
         if (d3 != 0) begin errors++; $display("FAIL lz_digit3 case=%0d got=%0d want=0", t, d3); end
         if (t == 0) begin
            checks++;
            if (hi != 0) begin errors++; $display("FAIL lz_0042_high got=%0d want=0", hi); end
            checks++;
            if (d1 != 6) begin errors++; $display("FAIL lz_0042_digit1 got=%0d want=6", d1); end
         end else if (t == 1) begin
            checks++;
            if (other != 0) begin errors++; $display("FAIL lz_0000_other got=%0d want=0", other); end
         end else begin
            checks++;
            if (d2 != 6) begin errors++; $display("FAIL lz_0102_digit2 got=%0d want=6", d2); end
            checks++;
            if (d1 != 6) begin errors++; $display("FAIL lz_0102_digit1 got=%0d want=6", d1); end
         end
      end
   endtask

   task automatic test_tear_free();
      int ones, nines, d0_nine;
      bit ok;
      logic [3:0] a;
      logic [6:0] s;
      digits_bcd = 16'h1111;
      lz_blank   = 1'b0;
      digit_en   = 4'b1111;
      dp_in      = 4'b0000;
      wait_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL tear_timeout got=0 want=1"); end
      capture(12, 0);
      checks++;
      if (cap_obs[11][12:9] !== 4'b1101) begin
         errors++; $display("FAIL tear_in_digit1 got=%b want=1101", cap_obs[11][12:9]);
      end
      digits_bcd = 16'h9999;
      capture(20, 12);
      ones = 0; nines = 0;
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (cap_obs[i] !== cap_exp[i]) begin
            errors++; $display("FAIL tear_sb i=%0d got=%b want=%b", i, cap_obs[i], cap_exp[i]);
         end
         a = cap_obs[i][12:9];
         s = cap_obs[i][8:2];
         if ((a == 4'b1011 || a == 4'b0111) && s == S_1) ones++;
         if (s == S_9) nines++;
      end
      checks++;
      if (ones != 12) begin errors++; $display("FAIL tear_old_digits got=%0d want=12", ones); end
      checks++;
      if (nines != 0) begin errors++; $display("FAIL tear_early_nine got=%0d want=0", nines); end
      capture(32, 0);
      d0_nine = 0; nines = 0;
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (cap_obs[i] !== cap_exp[i]) begin
            errors++; $display("FAIL tear_next_sb i=%0d got=%b want=%b", i, cap_obs[i], cap_exp[i]);
         end
         if (cap_obs[i][12:9] == 4'b1110 && cap_obs[i][8:2] == S_9) d0_nine++;
         if (cap_obs[i][8:2] == S_9) nines++;
      end
      checks++;
      if (d0_nine != 6) begin errors++; $display("FAIL tear_digit0_nine got=%0d want=6", d0_nine); end
      checks++;
      if (nines != 24) begin errors++; $display("FAIL tear_all_nine got=%0d want=24", nines); end
   endtask

   task automatic test_blank_dp();
      int d0, d1, d2, d3, dark;
      bit ok;
      logic [3:0] a;
      logic [6:0] s;
      logic       p;
      digits_bcd = 16'h5A35;
      digit_en   = 4'b1101;
      dp_in      = 4'b0001;
      lz_blank   = 1'b0;
      wait_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL blank_timeout got=0 want=1"); end
      capture(32, 0);
      d0 = 0; d1 = 0; d2 = 0; d3 = 0; dark = 0;
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (cap_obs[i] !== cap_exp[i]) begin
            errors++; $display("FAIL blank_sb i=%0d got=%b want=%b", i, cap_obs[i], cap_exp[i]);
         end
         a = cap_obs[i][12:9];
         s = cap_obs[i][8:2];
         p = cap_obs[i][1];
         if (a == 4'b1110 && s == S_5 && p == 1'b0) d0++;
         if (a == 4'b1101) d1++;
         if (a == 4'b1011) d2++;
         if (a == 4'b0111 && s == S_5 && p == 1'b1) d3++;
         if (a == 4'b1111 && s == 7'b1111111 && p == 1'b1) dark++;
      end
      checks++;
      if (d0 != 6) begin errors++; $display("FAIL blank_digit0_dp got=%0d want=6", d0); end
      checks++;
      if (d1 != 0) begin errors++; $display("FAIL blank_disabled got=%0d want=0", d1); end
      checks++;
      if (d2 != 0) begin errors++; $display("FAIL blank_code_a got=%0d want=0", d2); end
      checks++;
      if (d3 != 6) begin errors++; $display("FAIL blank_digit3 got=%0d want=6", d3); end
      checks++;
      if (dark != 20) begin errors++; $display("FAIL blank_dark_cycles got=%0d want=20", dark); end
   endtask

   task automatic test_mid_reset();
      logic [12:0] o, e;
      bit ok, found;
      int n;
      digits_bcd = 16'h1234;
      digit_en   = 4'b1111;
      dp_in      = 4'b0000;
      lz_blank   = 1'b0;
      wait_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL midrst_timeout got=0 want=1"); end
      capture(20, 0);
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (cap_obs[i] !== cap_exp[i]) begin
            errors++; $display("FAIL midrst_sb i=%0d got=%b want=%b", i, cap_obs[i], cap_exp[i]);
         end
      end
      checks++;
      if (cap_obs[19][12:9] !== 4'b1011) begin
         errors++; $display("FAIL midrst_in_digit2 got=%b want=1011", cap_obs[19][12:9]);
      end
      rst = 1'b1;
      step(o, e);
      checks++;
      if (o !== RST_VAL) begin errors++; $display("FAIL midrst_value got=%b want=%b", o, RST_VAL); end
      checks++;
      if (o !== e) begin errors++; $display("FAIL midrst_value_sb got=%b want=%b", o, e); end
      rst = 1'b0;
      n = 0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(o, e);
         n++;
         checks++;
         if (o !== e) begin errors++; $display("FAIL midrst_restart_sb n=%0d got=%b want=%b", n, o, e); end
         found = (o[12:9] === 4'b1110);
      end
      checks++;
      if (!found || n != DEAD_C + 1) begin
         errors++; $display("FAIL midrst_relight found=%0d got=%0d want=%0d", found, n, DEAD_C + 1);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      for (int f = 0; f < 4; f++) begin
         digits_bcd = (f == 0) ? 16'h6789 : 16'($urandom);
         digit_en   = (f == 0) ? 4'b1111 : 4'($urandom);
         dp_in      = 4'($urandom);
         lz_blank   = (f == 0) ? 1'b0 : 1'($urandom);
         wait_frame(ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL b2b_timeout frame=%0d got=0 want=1", f); end
         capture(32, 0);
         for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap_obs[i] !== cap_exp[i]) begin
               errors++; $display("FAIL b2b_sb frame=%0d i=%0d got=%b want=%b", f, i, cap_obs[i], cap_exp[i]);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_scan();
      test_leading_zero();
      test_tear_free();
      test_blank_dp();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
